// File: rtl/sram_access_ctrl.sv
// Sequencing controller for a 6T SRAM word array: one request at a time,
// driving precharge, wordline, write-driver and sense-amp enables in fixed phase order.
//
// state | meaning
// IDLE  | ready for a request
// PRECH | bitline precharge/equalize, timed by cnt
// WLACT | wordline on; write drivers on for writes, timed by cnt
// SENSE | wordline held, sense amps on, read data captured
// RESP  | one-cycle response pulse
module sram_access_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int PRECH_CYC = 1,
    parameter int WL_CYC    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   prech_en,
    output logic [(1<<ADDR_W)-1:0] wl,
    output logic                   wr_en,
    output logic [DATA_W-1:0]      bl_data,
    output logic                   sae,
    input  logic [DATA_W-1:0]      sa_data
);

    localparam int NUM_WL = 1 << ADDR_W;
    localparam int MAX_CYC = (PRECH_CYC > WL_CYC) ? PRECH_CYC : WL_CYC;
    localparam int CNT_W = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRECH = 3'd1,
        S_WLACT = 3'd2,
        S_SENSE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                prech_en_q, prech_en_d;
    logic [NUM_WL-1:0]   wl_q, wl_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   bl_data_q, bl_data_d;
    logic                sae_q, sae_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            prech_en_q  <= 1'b0;
            wl_q        <= '0;
            wr_en_q     <= 1'b0;
            bl_data_q   <= '0;
            sae_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            prech_en_q  <= prech_en_d;
            wl_q        <= wl_d;
            wr_en_q     <= wr_en_d;
            bl_data_q   <= bl_data_d;
            sae_q       <= sae_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(PRECH_CYC);
                    state_d = S_PRECH;
                end
            end
            S_PRECH: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = CNT_W'(WL_CYC);
                    state_d = S_WLACT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WLACT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = we_q ? S_RESP : S_SENSE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SENSE: begin
                rdata_d = sa_data;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Array outputs are decoded from the upcoming state so each flop is glitch-free
    // and lines up with the state it belongs to.
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        prech_en_d  = (state_d == S_PRECH);
        sae_d       = (state_d == S_SENSE);
        wr_en_d     = (state_d == S_WLACT) && we_d;
        bl_data_d   = wr_en_d ? wdata_d : '0;
        wl_d        = '0;
        if ((state_d == S_WLACT) || (state_d == S_SENSE)) begin
            wl_d = NUM_WL'(1) << addr_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign prech_en  = prech_en_q;
    assign wl        = wl_q;
    assign wr_en     = wr_en_q;
    assign bl_data   = bl_data_q;
    assign sae       = sae_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl: cycle-phase model plus directed
// vectors, with a small cell-array model answering the sense amps.
module tb_sram_access_ctrl;

    localparam int P = 1;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [3:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready, rsp_valid, prech_en, wr_en, sae;
    logic [7:0]  rsp_rdata, bl_data, sa_data;
    logic [15:0] wl;

    logic        req_valid2, req_we2;
    logic [3:0]  req_addr2;
    logic [7:0]  req_wdata2;
    logic        req_ready2, rsp_valid2, prech_en2, wr_en2, sae2;
    logic [7:0]  rsp_rdata2, bl_data2, sa_data2;
    logic [15:0] wl2;

    int n_cmp = 0;
    int n_bad = 0;
    int n_rsp = 0;
    int n_done = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sram_access_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .prech_en(prech_en),
        .wl(wl), .wr_en(wr_en), .bl_data(bl_data), .sae(sae), .sa_data(sa_data)
    );

    sram_access_ctrl #(.PRECH_CYC(3), .WL_CYC(1)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_we(req_we2), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .prech_en(prech_en2),
        .wl(wl2), .wr_en(wr_en2), .bl_data(bl_data2), .sae(sae2), .sa_data(sa_data2)
    );

    function automatic logic [7:0] pat(int i);
        return 8'(i * 37 + 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cell array: written by the write drivers, read through the sense amps.
    logic [7:0] arr [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) arr[i] <= pat(i);
        end else if (wr_en) begin
            for (int i = 0; i < 16; i++) if (wl[i]) arr[i] <= bl_data;
        end
    end

    always_comb begin
        sa_data = 8'hEE;
        if (sae) begin
            for (int i = 0; i < 16; i++) if (wl[i]) sa_data = arr[i];
        end
    end

    assign sa_data2 = sae2 ? 8'h3C : 8'h00;

    // Request-level model: position n within the access decides every output.
    bit         busy;
    int         n;
    bit         m_we;
    logic [3:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] exp_rdata;
    logic [7:0] mem [16];

    function automatic int lat(bit we);
        return P + W + (we ? 1 : 2);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            n         <= 0;
            exp_rdata <= 8'h00;
            for (int i = 0; i < 16; i++) mem[i] <= pat(i);
        end else if (!busy) begin
            if (req_valid) begin
                busy    <= 1'b1;
                n       <= 1;
                m_we    <= req_we;
                m_addr  <= req_addr;
                m_wdata <= req_wdata;
                if (req_we) mem[req_addr] <= req_wdata;
            end
        end else if (n == lat(m_we)) begin
            busy   <= 1'b0;
            n_done <= n_done + 1;
        end else begin
            n <= n + 1;
            if (!m_we && (n + 1 == P + W + 2)) exp_rdata <= mem[m_addr];
        end
    end

    always @(negedge clk) begin
        logic        e_prech, e_wr, e_sae, e_rsp, wlon;
        logic [15:0] e_wl;
        logic [7:0]  e_bl;
        if (chk_en) begin
            e_prech = busy && n >= 1 && n <= P;
            wlon    = busy && n > P && n <= P + W + (m_we ? 0 : 1);
            e_wl    = wlon ? (16'd1 << m_addr) : 16'd0;
            e_wr    = busy && m_we && n > P && n <= P + W;
            e_bl    = e_wr ? m_wdata : 8'h00;
            e_sae   = busy && !m_we && n == P + W + 1;
            e_rsp   = busy && n == lat(m_we);
            chk("m_req_ready", 32'(req_ready), 32'(!busy));
            chk("m_prech_en", 32'(prech_en), 32'(e_prech));
            chk("m_wl", 32'(wl), 32'(e_wl));
            chk("m_wr_en", 32'(wr_en), 32'(e_wr));
            chk("m_bl_data", 32'(bl_data), 32'(e_bl));
            chk("m_sae", 32'(sae), 32'(e_sae));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            chk("m_rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
            chk("inv_prech_wl", 32'(prech_en && (wl != 16'd0)), 32'd0);
            chk("inv_wr_sae", 32'(wr_en && sae), 32'd0);
            chk("inv_onehot", 32'($countones(wl) > 1), 32'd0);
            if (rsp_valid) n_rsp++;
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (!req_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: req_ready stayed 0 for %0d cycles, required 1", g);
        end
    endtask

    // Returns #1 into cycle 1 of the accepted access.
    task automatic do_req(input logic we, input logic [3:0] a, input logic [7:0] d);
        req_we = we;
        req_addr = a;
        req_wdata = d;
        req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = '0; req_wdata2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_wl", 32'(wl), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);

        // write addr 5 = 0xA5
        do_req(1'b1, 4'd5, 8'hA5);
        @(negedge clk);
        chk("wr_c1_prech", 32'(prech_en), 32'd1);
        chk("wr_c1_wl", 32'(wl), 32'd0);
        @(negedge clk);
        chk("wr_c2_wl", 32'(wl), 32'h0020);
        chk("wr_c2_wr_en", 32'(wr_en), 32'd1);
        chk("wr_c2_bl", 32'(bl_data), 32'hA5);
        @(negedge clk);
        chk("wr_c3_wl", 32'(wl), 32'h0020);
        chk("wr_c3_wr_en", 32'(wr_en), 32'd1);
        @(negedge clk);
        chk("wr_c4_rsp", 32'(rsp_valid), 32'd1);
        chk("wr_c4_rdata", 32'(rsp_rdata), 32'd0);
        chk("wr_c4_ready", 32'(req_ready), 32'd0);

        // read addr 5
        do_req(1'b0, 4'd5, 8'h00);
        @(negedge clk);
        chk("rd_c1_prech", 32'(prech_en), 32'd1);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            chk("rd_wl", 32'(wl), 32'h0020);
            chk("rd_sae", 32'(sae), (c == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("rd_c5_rsp", 32'(rsp_valid), 32'd1);
        chk("rd_c5_rdata", 32'(rsp_rdata), 32'hA5);

        // edge addresses
        do_req(1'b1, 4'd0, 8'h3C);
        @(negedge clk);
        @(negedge clk);
        chk("a0_wl", 32'(wl), 32'h0001);
        chk("a0_bl", 32'(bl_data), 32'h3C);
        @(negedge clk);
        @(negedge clk);
        chk("a0_rsp", 32'(rsp_valid), 32'd1);
        chk("a0_rdata_held", 32'(rsp_rdata), 32'hA5);
        do_req(1'b0, 4'd15, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("a15_wl", 32'(wl), 32'h8000);
        repeat (3) @(negedge clk);
        chk("a15_rsp", 32'(rsp_valid), 32'd1);
        chk("a15_rdata", 32'(rsp_rdata), 32'h2E);

        // backpressure: valid held, addr changing while busy
        req_we = 1'b0;
        req_addr = 4'd3;
        req_valid = 1'b1;
        wait_ready();
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            req_addr = 4'(c + 8);
            @(negedge clk);
            if (c == 2) chk("bp_first_wl", 32'(wl), 32'h0008);
            if (c == 5) chk("bp_first_rsp", 32'(rsp_valid), 32'd1);
            if (c == 6) chk("bp_ready_after_resp", 32'(req_ready), 32'd1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_prech", 32'(prech_en), 32'd1);
        @(negedge clk);
        chk("bp_second_wl", 32'(wl), 32'h4000);
        repeat (3) @(negedge clk);
        chk("bp_second_rsp", 32'(rsp_valid), 32'd1);

        // reset mid-WLACT of a read
        do_req(1'b0, 4'd9, 8'h00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rs_wl_before", 32'(wl), 32'h0200);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rs_wl", 32'(wl), 32'd0);
        chk("rs_prech", 32'(prech_en), 32'd0);
        chk("rs_sae", 32'(sae), 32'd0);
        chk("rs_wr_en", 32'(wr_en), 32'd0);
        chk("rs_bl", 32'(bl_data), 32'd0);
        chk("rs_ready", 32'(req_ready), 32'd1);
        chk("rs_rdata", 32'(rsp_rdata), 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rs_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // random traffic under the model and invariant monitor
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
        repeat (10) @(posedge clk);
        #1;
        chk("rsp_count", 32'(n_rsp), 32'(n_done));

        // PRECH_CYC = 3, WL_CYC = 1 read latency
        req_we2 = 1'b0;
        req_addr2 = 4'd7;
        req_valid2 = 1'b1;
        @(negedge clk);
        chk("p3_ready", 32'(req_ready2), 32'd1);
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (cnt == 3) chk("p3_c3_prech", 32'(prech_en2), 32'd1);
            if (cnt == 4) chk("p3_c4_wl", 32'(wl2), 32'h0080);
            if (cnt == 5) chk("p3_c5_sae", 32'(sae2), 32'd1);
            if (rsp_valid2) break;
        end
        chk("p3_latency", 32'(cnt), 32'd6);
        chk("p3_rdata", 32'(rsp_rdata2), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
